// File: rtl/blackjack_table_if.sv
// blackjack_table_if: player actions, card-source handshake and display outputs of the blackjack table
interface blackjack_table_if #(
  parameter int BET_W  = 4,
  parameter int COIN_W = 8
);
  logic              next;
  logic              hit;
  logic              stand;
  logic              double_down;
  logic              split;
  logic [BET_W-1:0]  bet;
  logic              card_req;
  logic              card_valid;
  logic [3:0]        card_value;
  logic [5:0]        player_score;
  logic [5:0]        player_score_split;
  logic [5:0]        dealer_score;
  logic [COIN_W-1:0] current_coin;
  logic              can_split;
  logic [2:0]        phase;
  logic [1:0]        win;
  logic [1:0]        lose;
  logic [1:0]        draw;
  modport master (
    output next, hit, stand, double_down, split, bet, card_valid, card_value,
    input  card_req, player_score, player_score_split, dealer_score, current_coin,
           can_split, phase, win, lose, draw
  );
  modport slave (
    input  next, hit, stand, double_down, split, bet, card_valid, card_value,
    output card_req, player_score, player_score_split, dealer_score, current_coin,
           can_split, phase, win, lose, draw
  );
endinterface

// File: rtl/blackjack_table.sv
// blackjack_table: one-round-per-bet blackjack controller with external card source; optional split via BLACKJACK_SPLIT_EN
module blackjack_table #(
  parameter int COIN_W       = 8,
  parameter int INIT_COIN    = 30,
  parameter int BET_W        = 4,
  parameter int MAX_CARDS    = 5,
  parameter int DEALER_STAND = 17
) (
  input logic              clk,
  input logic              reset,
  blackjack_table_if.slave bus
);
`ifdef BLACKJACK_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam int PW = COIN_W + BET_W + 3;
  localparam logic [1:0] HMASK = SPLIT_EN ? 2'b11 : 2'b01;
  typedef enum logic [2:0] {IDLE = 3'd0, DEAL = 3'd1, PLAY0 = 3'd2, PLAY1 = 3'd3, DEALER = 3'd4, RESULT = 3'd5} state_t;
  state_t            r_state;
  logic [5:0]        r_sum0, r_sum1, r_sumd;
  logic              r_ace0, r_ace1, r_aced;
  logic [2:0]        r_n0, r_n1, r_nd;
  logic [3:0]        r_c0a, r_c0b;
  logic [COIN_W-1:0] r_coin;
  logic [BET_W-1:0]  r_bet;
  logic [BET_W:0]    r_stake0, r_stake1;
  logic              r_split, r_dbl0, r_dbl1;
  logic              r_req;
  logic [1:0]        r_tgt;
  logic [2:0]        r_deal;
  logic [1:0]        r_win, r_lose, r_draw;
  function automatic logic [5:0] score(input logic [5:0] s, input logic a);
    return (a && s <= 6'd11) ? s + 6'd10 : s;
  endfunction
  function automatic logic [PW-1:0] pay(input logic [BET_W:0] st, input logic w, input logic d, input logic bj);
    return bj ? PW'(st) + PW'(st) + PW'(st >> 1) : w ? PW'(st) + PW'(st) : d ? PW'(st) : '0;
  endfunction
  logic [3:0]        w_card;
  logic              w_take;
  logic [5:0]        w_s0, w_s1, w_sd;
  logic              w_b0, w_b1, w_dbust, w_all_bust;
  logic              w_nat0, w_dnat, w_bj;
  logic              w_win0, w_draw0, w_win1, w_draw1;
  logic              w_coin_ok, w_bet_ok, w_can_split, w_enter, w_clr;
  logic [PW-1:0]     w_sum_coin;
  logic [COIN_W-1:0] w_new_coin;
  // Card decode, scores, round outcome and payout, all derived from registered state
  always_comb begin
    w_card     = bus.card_value >= 4'd10 ? 4'd10 : bus.card_value;
    w_take     = r_req && bus.card_valid && bus.card_value != 4'd0;
    w_s0       = score(r_sum0, r_ace0);
    w_s1       = score(r_sum1, r_ace1);
    w_sd       = score(r_sumd, r_aced);
    w_b0       = w_s0 > 6'd21;
    w_b1       = w_s1 > 6'd21;
    w_dbust    = w_sd > 6'd21;
    w_all_bust = w_b0 && (!r_split || w_b1);
    w_nat0     = !r_split && r_n0 == 3'd2 && w_s0 == 6'd21;
    w_dnat     = r_nd == 3'd2 && w_sd == 6'd21;
    w_bj       = w_nat0 && !w_dnat;
    w_win0     = w_bj || (!w_b0 && (w_dbust || w_s0 > w_sd));
    w_draw0    = !w_bj && !w_b0 && !w_dbust && w_s0 == w_sd;
    w_win1     = r_split && !w_b1 && (w_dbust || w_s1 > w_sd);
    w_draw1    = r_split && !w_b1 && !w_dbust && w_s1 == w_sd;
    w_coin_ok  = PW'(r_coin) >= PW'(r_bet);
    w_bet_ok   = bus.bet != '0 && PW'(bus.bet) <= PW'(r_coin);
    w_can_split = SPLIT_EN && r_state == PLAY0 && !r_req && r_n0 == 3'd2 && r_c0a == r_c0b && !r_split && w_coin_ok;
    w_enter    = !r_req && ((r_state == DEAL && r_deal == 3'd4 && w_nat0) ||
                            (r_state == DEALER && (w_all_bust || w_sd >= 6'(DEALER_STAND))));
    w_clr      = !r_req && r_state == RESULT && bus.next;
    w_sum_coin = PW'(r_coin) + pay(r_stake0, w_win0, w_draw0, w_bj) + pay(r_stake1, w_win1, w_draw1, 1'b0);
    w_new_coin = w_sum_coin > PW'({COIN_W{1'b1}}) ? {COIN_W{1'b1}} : w_sum_coin[COIN_W-1:0];
  end
  // Round FSM: card intake while a request is pending, otherwise per-phase action handling
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_coin  <= COIN_W'(INIT_COIN);
      r_bet   <= '0;
      r_req   <= 1'b0;
      r_tgt   <= 2'd0;
      r_deal  <= 3'd0;
    end else begin
      if (r_req) begin
        if (w_take) begin
          r_req <= 1'b0;
          case (r_tgt)
            2'd0: begin
              r_sum0 <= r_sum0 + 6'(w_card);
              r_ace0 <= r_ace0 | (w_card == 4'd1);
              r_n0   <= r_n0 + 3'd1;
              if (r_n0 == 3'd0) r_c0a <= w_card;
              if (r_n0 == 3'd1) r_c0b <= w_card;
            end
            2'd1: begin
              r_sum1 <= r_sum1 + 6'(w_card);
              r_ace1 <= r_ace1 | (w_card == 4'd1);
              r_n1   <= r_n1 + 3'd1;
            end
            default: begin
              r_sumd <= r_sumd + 6'(w_card);
              r_aced <= r_aced | (w_card == 4'd1);
              r_nd   <= r_nd + 3'd1;
            end
          endcase
        end
      end else begin
        case (r_state)
          IDLE:
            if (bus.next && w_bet_ok) begin
              r_coin   <= r_coin - COIN_W'(bus.bet);
              r_bet    <= bus.bet;
              r_stake0 <= (BET_W+1)'(bus.bet);
              r_deal   <= 3'd0;
              r_state  <= DEAL;
            end
          DEAL:
            if (r_deal != 3'd4) begin
              r_req  <= 1'b1;
              r_tgt  <= r_deal[0] ? 2'd2 : 2'd0;
              r_deal <= r_deal + 3'd1;
            end else r_state <= w_nat0 ? RESULT : PLAY0;
          PLAY0:
            if (w_b0 || r_n0 == 3'(MAX_CARDS) || r_dbl0) begin
              r_state <= r_split ? PLAY1 : DEALER;
              r_req   <= r_split;
              r_tgt   <= 2'd1;
            end else if (bus.split && w_can_split) begin
              r_coin   <= r_coin - COIN_W'(r_bet);
              r_stake1 <= (BET_W+1)'(r_bet);
              r_split  <= 1'b1;
              r_sum0   <= 6'(r_c0a);
              r_ace0   <= r_c0a == 4'd1;
              r_n0     <= 3'd1;
              r_sum1   <= 6'(r_c0b);
              r_ace1   <= r_c0b == 4'd1;
              r_n1     <= 3'd1;
              r_req    <= 1'b1;
              r_tgt    <= 2'd0;
            end else if (bus.double_down && r_n0 == 3'd2 && w_coin_ok) begin
              r_coin   <= r_coin - COIN_W'(r_bet);
              r_stake0 <= r_stake0 + (BET_W+1)'(r_bet);
              r_dbl0   <= 1'b1;
              r_req    <= 1'b1;
              r_tgt    <= 2'd0;
            end else if (bus.hit) begin
              r_req <= 1'b1;
              r_tgt <= 2'd0;
            end else if (bus.stand) begin
              r_state <= r_split ? PLAY1 : DEALER;
              r_req   <= r_split;
              r_tgt   <= 2'd1;
            end
          PLAY1:
            if (w_b1 || r_n1 == 3'(MAX_CARDS) || r_dbl1 || (bus.stand && !bus.hit && !bus.double_down)) r_state <= DEALER;
            else if (bus.double_down && r_n1 == 3'd2 && w_coin_ok) begin
              r_coin   <= r_coin - COIN_W'(r_bet);
              r_stake1 <= r_stake1 + (BET_W+1)'(r_bet);
              r_dbl1   <= 1'b1;
              r_req    <= 1'b1;
              r_tgt    <= 2'd1;
            end else if (bus.hit) begin
              r_req <= 1'b1;
              r_tgt <= 2'd1;
            end
          DEALER:
            if (w_all_bust || w_sd >= 6'(DEALER_STAND)) r_state <= RESULT;
            else begin
              r_req <= 1'b1;
              r_tgt <= 2'd2;
            end
          default:
            if (bus.next) r_state <= IDLE;
        endcase
      end
      if (w_enter) begin
        r_coin <= w_new_coin;
        r_win  <= {w_win1, w_win0};
        r_draw <= {w_draw1, w_draw0};
        r_lose <= {r_split && !w_win1 && !w_draw1, !w_win0 && !w_draw0};
      end
    end
    if (reset || w_clr) begin
      {r_sum0, r_sum1, r_sumd} <= '0;
      {r_ace0, r_ace1, r_aced} <= '0;
      {r_n0, r_n1, r_nd}       <= '0;
      {r_c0a, r_c0b}           <= '0;
      {r_stake0, r_stake1}     <= '0;
      {r_split, r_dbl0, r_dbl1} <= '0;
      {r_win, r_lose, r_draw}  <= '0;
    end
  end
  assign bus.card_req           = r_req;
  assign bus.player_score       = w_s0;
  assign bus.player_score_split = SPLIT_EN ? w_s1 : 6'd0;
  assign bus.dealer_score       = w_sd;
  assign bus.current_coin       = r_coin;
  assign bus.can_split          = w_can_split;
  assign bus.phase              = r_state;
  assign bus.win                = r_win & HMASK;
  assign bus.lose               = r_lose & HMASK;
  assign bus.draw               = r_draw & HMASK;
endmodule

// File: tb/tb_blackjack_table.sv
// tb_blackjack_table: directed rounds with a result scoreboard checked by an independent monitor
module tb_blackjack_table;
  localparam int NEXT = 0, HIT = 1, STAND = 2, DBL = 3, SPL = 4;
  typedef struct {
    string      name;
    logic [1:0] w, l, d;
    logic [7:0] coin;
    logic [5:0] ps, pss, ds;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [3:0] cards[$];
  bit stall = 1'b0;
  logic [2:0] prev_phase;
  exp_t e;
  always #5 clk = ~clk;
  blackjack_table_if #(.BET_W(5), .COIN_W(8)) bus ();
  blackjack_table #(.COIN_W(8), .INIT_COIN(30), .BET_W(5), .MAX_CARDS(5), .DEALER_STAND(17)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  // Card source: offers the next queued card whenever a card is requested and not stalled
  initial begin
    bus.card_valid = 1'b0;
    bus.card_value = 4'd0;
    forever begin
      @(negedge clk);
      bus.card_valid = 1'b0;
      if (bus.card_req && !stall && cards.size() > 0) begin
        bus.card_valid = 1'b1;
        bus.card_value = cards.pop_front();
      end
    end
  end
  // Monitor: on each entry into RESULT, compare the presented outcome with the oldest expectation
  always @(negedge clk) begin
    if (bus.phase == 3'd5 && prev_phase != 3'd5) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: RESULT entered with no expectation queued");
      end else begin
        e = sb.pop_front();
        if ({bus.win, bus.lose, bus.draw, bus.current_coin, bus.player_score, bus.player_score_split, bus.dealer_score}
            !== {e.w, e.l, e.d, e.coin, e.ps, e.pss, e.ds}) begin
          errors++;
          $display("FAIL %s: got win=%b lose=%b draw=%b coin=%0d ps=%0d pss=%0d ds=%0d, want win=%b lose=%b draw=%b coin=%0d ps=%0d pss=%0d ds=%0d",
                   e.name, bus.win, bus.lose, bus.draw, bus.current_coin, bus.player_score, bus.player_score_split,
                   bus.dealer_score, e.w, e.l, e.d, e.coin, e.ps, e.pss, e.ds);
        end
      end
    end
    prev_phase <= bus.phase;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic expect_result(input string name, input logic [1:0] w, input logic [1:0] l, input logic [1:0] d,
                               input logic [7:0] coin, input logic [5:0] ps, input logic [5:0] pss, input logic [5:0] ds);
    exp_t x;
    x.name = name; x.w = w; x.l = l; x.d = d; x.coin = coin; x.ps = ps; x.pss = pss; x.ds = ds;
    sb.push_back(x);
  endtask
  task automatic press(input int k);
    @(negedge clk);
    case (k)
      NEXT:    bus.next = 1'b1;
      HIT:     bus.hit = 1'b1;
      STAND:   bus.stand = 1'b1;
      DBL:     bus.double_down = 1'b1;
      default: bus.split = 1'b1;
    endcase
    @(negedge clk);
    {bus.next, bus.hit, bus.stand, bus.double_down, bus.split} = '0;
  endtask
  task automatic wait_phase(input logic [2:0] p, input string name);
    int n = 0;
    while (bus.phase !== p && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.phase), int'(p));
  endtask
  task automatic wait_quiet(input string name);
    int n = 0;
    @(negedge clk);
    while ((bus.card_req || cards.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL %s: card request still pending after 100 cycles, want idle", name);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic bet_round(input logic [4:0] b, input int coin_after, input string name);
    bus.bet = b;
    press(NEXT);
    chk(name, int'(bus.current_coin), coin_after);
  endtask
  initial begin
    {bus.next, bus.hit, bus.stand, bus.double_down, bus.split} = '0;
    bus.bet = '0;
    do_reset();
    chk("reset_phase", int'(bus.phase), 0);
    chk("reset_coin", int'(bus.current_coin), 30);
    chk("reset_scores", int'({bus.player_score, bus.player_score_split, bus.dealer_score}), 0);
    chk("reset_flags", int'({bus.card_req, bus.can_split, bus.win, bus.lose, bus.draw}), 0);
    // push 17 vs 17
    cards = '{4'd10, 4'd9, 4'd7, 4'd8};
    bet_round(5'd5, 25, "push_debit");
    wait_phase(3'd2, "push_play0");
    chk("push_ps", int'(bus.player_score), 17);
    chk("push_ds", int'(bus.dealer_score), 17);
    expect_result("push", 2'b00, 2'b00, 2'b01, 8'd30, 6'd17, 6'd0, 6'd17);
    press(STAND);
    wait_phase(3'd5, "push_result");
    press(NEXT);
    chk("push_clear", int'({bus.phase, bus.player_score, bus.dealer_score, bus.draw}), 0);
    // natural blackjack pays 2.5x
    cards = '{4'd1, 4'd10, 4'd10, 4'd7};
    expect_result("natural", 2'b01, 2'b00, 2'b00, 8'd36, 6'd21, 6'd0, 6'd17);
    bet_round(5'd4, 26, "nat_debit");
    wait_phase(3'd5, "nat_result");
    press(NEXT);
    // soft ace turning hard, dealer draws to 21
    do_reset();
    cards = '{4'd1, 4'd10, 4'd6, 4'd6};
    bet_round(5'd4, 26, "soft_debit");
    wait_phase(3'd2, "soft_play0");
    chk("soft_ps", int'(bus.player_score), 17);
    cards.push_back(4'd10);
    press(HIT);
    wait_quiet("soft_hit");
    chk("soft_hard_ps", int'(bus.player_score), 17);
    cards.push_back(4'd5);
    expect_result("soft_ace", 2'b00, 2'b01, 2'b00, 8'd26, 6'd17, 6'd0, 6'd21);
    press(STAND);
    wait_phase(3'd5, "soft_result");
    press(NEXT);
    // card source stall with a hit pulse and a zero card value in the way
    do_reset();
    stall = 1'b1;
    cards = '{4'd0, 4'd10, 4'd9, 4'd7, 4'd8};
    bet_round(5'd5, 25, "stall_debit");
    @(negedge clk);
    chk("stall_req1", int'(bus.card_req), 1);
    bus.hit = 1'b1;
    @(negedge clk);
    bus.hit = 1'b0;
    chk("stall_req2", int'({bus.card_req, bus.phase}), 'b1_001);
    @(negedge clk);
    chk("stall_req3", int'({bus.card_req, bus.phase}), 'b1_001);
    chk("stall_scores", int'({bus.player_score, bus.dealer_score}), 0);
    stall = 1'b0;
    wait_phase(3'd2, "stall_play0");
    chk("stall_ps", int'(bus.player_score), 17);
    chk("stall_ds", int'(bus.dealer_score), 17);
    expect_result("stall_push", 2'b00, 2'b00, 2'b01, 8'd30, 6'd17, 6'd0, 6'd17);
    press(STAND);
    wait_phase(3'd5, "stall_result");
    press(NEXT);
    // bet limits and illegal double
    do_reset();
    bet_round(5'd0, 30, "bet0_coin");
    chk("bet0_phase", int'(bus.phase), 0);
    bet_round(5'd31, 30, "bet31_coin");
    chk("bet31_phase", int'(bus.phase), 0);
    cards = '{4'd5, 4'd9, 4'd6, 4'd8};
    bet_round(5'd20, 10, "bet20_coin");
    wait_phase(3'd2, "dbl_bad_play0");
    press(DBL);
    wait_quiet("dbl_bad");
    chk("dbl_bad_state", int'({bus.card_req, bus.phase, bus.player_score}), {1'b0, 3'd2, 6'd11});
    chk("dbl_bad_coin", int'(bus.current_coin), 10);
    expect_result("dbl_bad_lose", 2'b00, 2'b01, 2'b00, 8'd10, 6'd11, 6'd0, 6'd17);
    press(STAND);
    wait_phase(3'd5, "dbl_bad_result");
    press(NEXT);
    // legal double with coin exactly equal to bet
    cards = '{4'd5, 4'd9, 4'd6, 4'd8, 4'd10};
    bet_round(5'd5, 5, "dbl_debit");
    wait_phase(3'd2, "dbl_play0");
    expect_result("double_win", 2'b01, 2'b00, 2'b00, 8'd20, 6'd21, 6'd0, 6'd17);
    press(DBL);
    chk("dbl_coin", int'(bus.current_coin), 0);
    wait_phase(3'd5, "dbl_result");
    press(NEXT);
    // player bust skips the dealer draw
    cards = '{4'd10, 4'd9, 4'd6, 4'd5};
    bet_round(5'd5, 15, "bust_debit");
    wait_phase(3'd2, "bust_play0");
    cards.push_back(4'd10);
    cards.push_back(4'd10);
    expect_result("bust", 2'b00, 2'b01, 2'b00, 8'd15, 6'd26, 6'd0, 6'd14);
    press(HIT);
    wait_phase(3'd5, "bust_result");
    chk("bust_card_left", cards.size(), 1);
    press(NEXT);
    cards.delete();
    // five-card limit forces stand
    cards = '{4'd2, 4'd10, 4'd2, 4'd7};
    bet_round(5'd2, 13, "max_debit");
    wait_phase(3'd2, "max_play0");
    cards.push_back(4'd2);
    press(HIT);
    wait_quiet("max_hit1");
    cards.push_back(4'd2);
    press(HIT);
    wait_quiet("max_hit2");
    chk("max_still_play", int'(bus.phase), 2);
    cards.push_back(4'd3);
    expect_result("max_cards", 2'b00, 2'b01, 2'b00, 8'd13, 6'd11, 6'd0, 6'd17);
    press(HIT);
    wait_phase(3'd5, "max_result");
    press(NEXT);
    // pair of eights
    do_reset();
    cards = '{4'd8, 4'd10, 4'd8, 4'd7};
    bet_round(5'd5, 25, "pair_debit");
    wait_phase(3'd2, "pair_play0");
`ifdef BLACKJACK_SPLIT_EN
    chk("pair_can_split", int'(bus.can_split), 1);
    cards.push_back(4'd3);
    press(SPL);
    wait_quiet("split_draw0");
    chk("split_coin", int'(bus.current_coin), 20);
    chk("split_scores", int'({bus.player_score, bus.player_score_split}), {6'd11, 6'd8});
    cards.push_back(4'd10);
    press(HIT);
    wait_quiet("split_hit");
    chk("split_ps21", int'(bus.player_score), 21);
    cards.push_back(4'd2);
    press(STAND);
    wait_quiet("split_draw1");
    chk("split_play1", int'({bus.phase, bus.player_score_split}), {3'd3, 6'd10});
    expect_result("split", 2'b01, 2'b10, 2'b00, 8'd30, 6'd21, 6'd10, 6'd17);
    press(STAND);
    wait_phase(3'd5, "split_result");
`else
    chk("pair_can_split", int'(bus.can_split), 0);
    press(SPL);
    wait_quiet("pair_split_ignored");
    chk("pair_state", int'({bus.card_req, bus.phase, bus.player_score, bus.player_score_split}), {1'b0, 3'd2, 6'd16, 6'd0});
    chk("pair_coin", int'(bus.current_coin), 25);
    expect_result("pair_lose", 2'b00, 2'b01, 2'b00, 8'd25, 6'd16, 6'd0, 6'd17);
    press(STAND);
    wait_phase(3'd5, "pair_result");
`endif
    press(NEXT);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blackjack_table.md
Name: blackjack_table

Overview:
- Parametrised successor of the single-hand blackjack game controller.
- Runs one round per bet: betting, dealing, player turn (hit/stand/double, optional split), dealer play, result and payout.
- Draws cards from an external card source over a req/valid handshake instead of a hard-wired generator.
- Sits between the pushbutton/switch input logic and the score/coin display logic.

Parameters:
- COIN_W, 8: width of the coin counter.
- INIT_COIN, 30: coin value loaded at reset.
- BET_W, 4: width of the bet input.
- MAX_CARDS, 5: cards per hand. Reaching this count forces stand. Legal range 3..6.
- DEALER_STAND, 17: dealer draws while its score is below this value (dealer stands on soft totals).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- next  in  1  confirm bet / leave result.
- hit  in  1  request one card.
- stand  in  1  end the turn for the active hand.
- double_down  in  1  double the bet, take one card, then stand.
- split  in  1  split a pair.
- bet  in  BET_W  bet amount.
- card_req  out  1  a card is wanted.
- card_valid  in  1  card_value is valid this cycle.
- card_value  in  4  card rank: 1 = ace, 2..10; values 11..15 count as 10.
- player_score  out  6  score of hand 0.
- player_score_split  out  6  score of hand 1.
- dealer_score  out  6  dealer score.
- current_coin  out  COIN_W  coin balance.
- can_split  out  1  split is currently legal.
- phase  out  3  FSM state code.
- win  out  2  per-hand result, bit h = hand h.
- lose  out  2  per-hand result, bit h = hand h.
- draw  out  2  per-hand result, bit h = hand h.

Behaviour:
- Reset values: FSM in IDLE; all scores 0; card_req 0; can_split 0; win/lose/draw 0; current_coin = INIT_COIN; all hands cleared.
- Handshake:
  - A card is consumed on any cycle where card_req && card_valid. card_req stays high until that cycle.
  - card_value 0 is ignored and the request stays pending.
  - Score outputs update on the cycle after the card is consumed.
  - All action inputs are ignored while card_req is high.
- Scoring:
  - Each hand keeps a hard sum and an ace flag.
  - score = sum + 10 if an ace is present and sum + 10 <= 21; otherwise score = sum.
  - Scores are combinational from registers.
- State codes: IDLE=0, DEAL=1, PLAY0=2, PLAY1=3, DEALER=4, RESULT=5.
- IDLE:
  - On next with 1 <= bet <= current_coin: subtract bet and go to DEAL.
  - Any other bet is ignored. Coin 0 leaves the block stuck in IDLE until reset.
- DEAL:
  - Four draws in order: player, dealer, player, dealer. Then go to PLAY0.
  - Natural: if the player has 21 on two cards, go directly to RESULT.
- PLAY0 / PLAY1:
  - Priority when several inputs are high: split > double_down > hit > stand.
  - hit: draw one card. Bust (score > 21) or card count == MAX_CARDS ends the hand automatically.
  - double_down: legal only with exactly 2 cards and coin >= bet. Subtract bet, double that hand's stake, draw one card, end the hand. Otherwise ignored.
- Hand end and dealer:
  - When PLAY0 ends: go to PLAY1 if split is active, else DEALER.
  - When PLAY1 ends: go to DEALER.
  - If every player hand is bust, skip dealer draws.
  - DEALER draws while dealer_score < DEALER_STAND, then goes to RESULT.
- RESULT:
  - Per active hand: player bust -> lose; else dealer bust -> win; else compare scores, higher wins, equal -> draw.
  - A natural (2-card 21, no split) against a non-natural dealer is a blackjack win.
  - Payout is added once, on entry to RESULT: win 2*stake, draw 1*stake, blackjack stake + stake + floor(stake/2), lose 0.
  - The coin counter saturates at 2^COIN_W - 1.
  - Results hold until next; next clears hands, scores and results and returns to IDLE.
- Reset mid-round aborts the round; the stake is not refunded.

Optional Feature:
- Macro: BLACKJACK_SPLIT_EN.
- Defined:
  - can_split = 1 in PLAY0 when both player cards have equal value, no split has been done yet, and coin >= bet.
  - On split: subtract bet, move card 2 into hand 1, hand 0 draws one card, play continues in PLAY0.
  - On entry to PLAY1, hand 1 draws one card.
  - A 21 after split is never a natural.
- Undefined: split is ignored; can_split, player_score_split, win[1], lose[1] and draw[1] are tied to 0; the PLAY1 state is unreachable.

Test Plan:
- Push: bet=5, next, cards 10,9,7,8 (player 17, dealer 17), stand -> draw=01, coin 25 then 30, phase=5.
- Natural: bet=4, cards 1,10,10,7 -> RESULT without player input, win=01, coin 26 then 36.
- Soft ace: bet=4, cards 1,10,6,6 -> player_score 17; hit with 10 -> 17 (hard); stand; dealer (16) draws 5 -> 21, lose=01, coin 26.
- Stall: hold card_valid=0 for 3 cycles after next -> card_req=1 throughout, scores and phase unchanged; a hit pulse during the stall is ignored.
- Split (macro defined): bet=5, cards 8,10,8,7, can_split=1, split; card 3 (hand 0 = 11), hit 10 (21), stand; hand 1 draws 2 (10), stand; dealer stands on 17 -> win=01, lose=10, coin 20 then 30.
- Limits: bet=0 or bet=31 with coin 30 -> IDLE held, coin unchanged; after betting 20, double_down with coin 10 -> ignored.
